// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and width helpers for the sequential comparator.
//   cmp_state_t - controller FSM states (IDLE, CMP, DONE)
//   slice_res_t - outcome of one 2-bit slice compare (EQ, LT, GT)
//   steps_width - width of the 'steps' counter for an operand width w
//   idx_width   - width of the slice index for an operand width w
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    LT = 2'd1,
    GT = 2'd2
  } slice_res_t;

  // Counter must hold values 0..S, where S = w/2.
  function automatic int steps_width(input int w);
    return ((w / 2 + 1) > 1) ? $clog2(w / 2 + 1) : 1;
  endfunction

  // Index must hold values 0..S-1; keep at least one bit for S = 1.
  function automatic int idx_width(input int w);
    return ((w / 2) > 1) ? $clog2(w / 2) : 1;
  endfunction

endpackage

// File: rtl/cmp_slice2.sv
// cmp_slice2: combinational 2-bit magnitude compare.
// Ports:
//   a   in  2  first operand slice
//   b   in  2  second operand slice
//   res out    EQ / LT / GT outcome of a versus b (unsigned)
module cmp_slice2
  import cmp_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output slice_res_t res
);

  always_comb begin
    res = EQ;
    if (a < b) begin
      res = LT;
    end else if (a > b) begin
      res = GT;
    end
  end

endmodule

// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: sequential magnitude comparator. Accepts an operand pair over
// a valid/ready handshake, walks 2-bit slices MSB-first through one shared
// cmp_slice2, stops at the first unequal slice and presents a registered
// eq/lt/gt/steps result over a second valid/ready handshake.
//
// Ports:
//   clk          in      clock, all state changes on the rising edge
//   rst_n        in      synchronous active-low reset
//   start_valid  in      operand pair on x/y is valid
//   start_ready  out     controller is idle and can accept operands
//   x, y         in  W   operands, sampled only on accept
//   res_valid    out     result outputs are valid
//   res_ready    in      consumer takes the result
//   eq, lt, gt   out     comparison result (one-hot while res_valid)
//   steps        out     number of slices examined for this result
//
// Build option: define CMP_SIGNED_EN for a two's-complement compare (the top
// slice sees both sign bits inverted). Undefined gives an unsigned compare.
module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [W-1:0]              x,
  input  logic [W-1:0]              y,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      eq,
  output logic                      lt,
  output logic                      gt,
  output logic [steps_width(W)-1:0] steps
);

  localparam int S  = W / 2;
  localparam int IW = idx_width(W);
  localparam int SW = steps_width(W);
  localparam logic [IW-1:0] IDX_TOP = IW'(S - 1);

  cmp_state_t     state_reg;
  cmp_state_t     state_next;
  logic [W-1:0]   x_reg;
  logic [W-1:0]   y_reg;
  logic [IW-1:0]  idx_reg;
  logic [SW-1:0]  steps_reg;
  logic           eq_reg;
  logic           lt_reg;
  logic           gt_reg;

  logic [1:0]     x_slice [S];
  logic [1:0]     y_slice [S];
  logic [1:0]     a_sel;
  logic [1:0]     b_sel;
  slice_res_t     slice_res;
  logic           accept;

  // Split the latched operands into slices. Only the top slice differs
  // between builds: flipping both sign bits maps two's complement order onto
  // unsigned order, so the same unsigned slice compare works for both.
  generate
    for (genvar gi = 0; gi < S; gi++) begin : g_slice
      if (gi == S - 1) begin : g_top
`ifdef CMP_SIGNED_EN
        assign x_slice[gi] = {~x_reg[2*gi+1], x_reg[2*gi]};
        assign y_slice[gi] = {~y_reg[2*gi+1], y_reg[2*gi]};
`else
        assign x_slice[gi] = x_reg[2*gi +: 2];
        assign y_slice[gi] = y_reg[2*gi +: 2];
`endif
      end else begin : g_low
        assign x_slice[gi] = x_reg[2*gi +: 2];
        assign y_slice[gi] = y_reg[2*gi +: 2];
      end
    end
  endgenerate

  // Single shared slice comparator fed by the idx-selected mux.
  assign a_sel = x_slice[idx_reg];
  assign b_sel = y_slice[idx_reg];

  cmp_slice2 u_slice (
    .a   (a_sel),
    .b   (b_sel),
    .res (slice_res)
  );

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_valid) begin
          accept     = 1'b1;
          state_next = CMP;
        end
      end
      CMP: begin
        // Finish on the first unequal slice, or after the last (LSB) slice.
        if (slice_res != EQ || idx_reg == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, operand, index, counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      idx_reg   <= '0;
      steps_reg <= '0;
      eq_reg    <= 1'b0;
      lt_reg    <= 1'b0;
      gt_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        x_reg     <= x;
        y_reg     <= y;
        idx_reg   <= IDX_TOP;
        steps_reg <= '0;
        eq_reg    <= 1'b0;
        lt_reg    <= 1'b0;
        gt_reg    <= 1'b0;
      end else if (state_reg == CMP) begin
        steps_reg <= steps_reg + SW'(1);
        case (slice_res)
          LT: lt_reg <= 1'b1;
          GT: gt_reg <= 1'b1;
          default: begin
            if (idx_reg == '0) begin
              eq_reg <= 1'b1;
            end else begin
              idx_reg <= idx_reg - IW'(1);
            end
          end
        endcase
      end
    end
  end

  // Handshake flags decode straight from the state register; results are
  // registered, so no input reaches an output combinationally.
  assign start_ready = (state_reg == IDLE);
  assign res_valid   = (state_reg == DONE);
  assign eq          = eq_reg;
  assign lt          = lt_reg;
  assign gt          = gt_reg;
  assign steps       = steps_reg;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb_cmp_seq_ctrl: self-checking bench for cmp_seq_ctrl with W = 8.
// Table-driven vectors, hand-written multi-cycle sequences (backpressure,
// reset mid-operation, back-to-back) and randomized pairs checked against an
// arithmetic reference model. Follows CMP_SIGNED_EN if defined.
module tb_cmp_seq_ctrl;

  localparam int W  = 8;
  localparam int S  = W / 2;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_valid;
  logic          start_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          res_valid;
  logic          res_ready;
  logic          eq;
  logic          lt;
  logic          gt;
  logic [SW-1:0] steps;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cmp_seq_ctrl #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .x           (x),
    .y           (y),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .eq          (eq),
    .lt          (lt),
    .gt          (gt),
    .steps       (steps)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       e;
    logic       l;
    logic       g;
    int         st;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input int act, input int req);
    total_cnt++;
    if (act == req) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Reference model: ordinary integer comparison, and the step count from the
  // position of the most significant differing bit.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic e, output logic l, output logic g,
                       output int st);
    int hb;
    hb = -1;
    for (int i = W - 1; i >= 0; i--) begin
      if (hb < 0 && a[i] != b[i]) hb = i;
    end
    st = (hb < 0) ? S : S - hb / 2;
`ifdef CMP_SIGNED_EN
    e = ($signed(a) == $signed(b));
    l = ($signed(a) <  $signed(b));
    g = ($signed(a) >  $signed(b));
`else
    e = (a == b);
    l = (a <  b);
    g = (a >  b);
`endif
  endtask

  // One operation. Called at posedge+1 with the controller expected idle.
  // With rel = 1 the result is taken (res_ready must be 1) and the IDLE gap
  // cycle is checked; with rel = 0 the controller is left in DONE.
  task automatic run_op(input logic [7:0] xv, input logic [7:0] yv,
                        input logic ee, input logic el, input logic eg,
                        input int es, input string nm, input bit rel);
    int  n;
    bit  seen;
    bit  rdy;
    rdy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (start_ready) begin
        rdy = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check({nm, " start_ready"}, int'(rdy), 1);
    x = xv;
    y = yv;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    x = 8'($urandom);
    y = 8'($urandom);
    seen = 1'b0;
    n = 0;
    for (int c = 1; c <= S + 2; c++) begin
      @(posedge clk); #1;
      if (res_valid) begin
        n = c;
        seen = 1'b1;
        break;
      end
    end
    check({nm, " res_valid seen"}, int'(seen), 1);
    if (seen) begin
      check({nm, " latency"}, n, es);
      check({nm, " eq"}, int'(eq), int'(ee));
      check({nm, " lt"}, int'(lt), int'(el));
      check({nm, " gt"}, int'(gt), int'(eg));
      check({nm, " steps"}, int'(steps), es);
      $display("op %s x=%h y=%h eq=%b lt=%b gt=%b steps=%0d latency=%0d",
               nm, xv, yv, eq, lt, gt, steps, n);
      if (rel) begin
        @(posedge clk); #1;
        check({nm, " idle res_valid"}, int'(res_valid), 0);
        check({nm, " idle start_ready"}, int'(start_ready), 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       me, ml, mg;
    int         mst;
    logic [7:0] rx, ry;
    int         acc_cyc [3];
    int         k, got, cyc;
    bit         acc;
    bit         rv_seen;

    vecs[0] = '{8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 4};
`ifdef CMP_SIGNED_EN
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1};
`else
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1};
`endif
    vecs[2] = '{8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 4};
    vecs[3] = '{8'h40, 8'h10, 1'b0, 1'b0, 1'b1, 1};
    vecs[4] = '{8'h03, 8'h01, 1'b0, 1'b0, 1'b1, 4};
    vecs[5] = '{8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 4};
`ifdef CMP_SIGNED_EN
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1};
`else
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1};
`endif
    vecs[7] = '{8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 4};

    // Reset state.
    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b1;
    x           = '0;
    y           = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset start_ready", int'(start_ready), 1);
    check("reset res_valid", int'(res_valid), 0);
    check("reset eq", int'(eq), 0);
    check("reset lt", int'(lt), 0);
    check("reset gt", int'(gt), 0);
    check("reset steps", int'(steps), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].e, vecs[i].l, vecs[i].g,
             vecs[i].st, $sformatf("vec%0d", i), 1'b1);
    end

    // Backpressure: result held while res_ready is low and start_valid toggles.
    res_ready = 1'b0;
    run_op(vecs[3].x, vecs[3].y, vecs[3].e, vecs[3].l, vecs[3].g,
           vecs[3].st, "bp", 1'b0);
    for (int i = 0; i < 5; i++) begin
      start_valid = (i % 2 == 0);
      x = 8'($urandom);
      y = 8'($urandom);
      @(posedge clk); #1;
      check("bp hold res_valid", int'(res_valid), 1);
      check("bp hold start_ready", int'(start_ready), 0);
      check("bp hold gt", int'(gt), 1);
      check("bp hold lt", int'(lt), 0);
      check("bp hold steps", int'(steps), 1);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk); #1;
    check("bp release start_ready", int'(start_ready), 1);
    check("bp release res_valid", int'(res_valid), 0);
    check("bp after gt kept", int'(gt), 1);
    check("bp after steps kept", int'(steps), 1);
    $display("op bp release: start_ready=%b gt=%b steps=%0d", start_ready, gt, steps);

    // Reset in the middle of a compare of equal operands.
    x = 8'h11;
    y = 8'h11;
    start_valid = 1'b1;
    @(posedge clk); #1;                // t0: accept
    start_valid = 1'b0;
    check("rst mid res_valid t0", int'(res_valid), 0);
    @(posedge clk); #1;                // t0+1
    check("rst mid res_valid t1", int'(res_valid), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;                // t0+2: reset edge
    rst_n = 1'b1;
    check("rst mid start_ready", int'(start_ready), 1);
    check("rst mid res_valid", int'(res_valid), 0);
    check("rst mid eq", int'(eq), 0);
    check("rst mid lt", int'(lt), 0);
    check("rst mid gt", int'(gt), 0);
    check("rst mid steps", int'(steps), 0);
    rv_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (res_valid) rv_seen = 1'b1;
    end
    check("rst mid no result", int'(rv_seen), 0);
    $display("op rst mid-op aborted: start_ready=%b res_valid=%b", start_ready, res_valid);
    run_op(vecs[4].x, vecs[4].y, vecs[4].e, vecs[4].l, vecs[4].g,
           vecs[4].st, "post_rst", 1'b1);

    // Back-to-back with start_valid and res_ready held high.
    k = 0;
    got = 0;
    cyc = 0;
    res_ready = 1'b1;
    x = vecs[5].x;
    y = vecs[5].y;
    start_valid = 1'b1;
    while (got < 3 && cyc < 60) begin
      acc = start_ready && start_valid;
      @(posedge clk); #1;
      if (acc && k < 3) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 3) begin
          x = vecs[5 + k].x;
          y = vecs[5 + k].y;
        end else begin
          start_valid = 1'b0;
        end
      end
      if (res_valid) begin
        check("b2b eq", int'(eq), int'(vecs[5 + got].e));
        check("b2b lt", int'(lt), int'(vecs[5 + got].l));
        check("b2b gt", int'(gt), int'(vecs[5 + got].g));
        check("b2b steps", int'(steps), vecs[5 + got].st);
        $display("op b2b%0d x=%h y=%h eq=%b lt=%b gt=%b steps=%0d",
                 got, vecs[5 + got].x, vecs[5 + got].y, eq, lt, gt, steps);
        got++;
      end
      cyc++;
    end
    start_valid = 1'b0;
    check("b2b results", got, 3);
    if (got == 3 && k == 3) begin
      check("b2b spacing 0-1", acc_cyc[1] - acc_cyc[0], vecs[5].st + 2);
      check("b2b spacing 1-2", acc_cyc[2] - acc_cyc[1], vecs[6].st + 2);
    end
    @(posedge clk); #1;

    // Randomized pairs against the reference model.
    for (int i = 0; i < 120; i++) begin
      rx = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       ry = rx;
        1:       ry = rx ^ (8'h01 << $urandom_range(0, 7));
        default: ry = 8'($urandom);
      endcase
      model(rx, ry, me, ml, mg, mst);
      run_op(rx, ry, me, ml, mg, mst, $sformatf("rnd%0d", i), 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cmp_seq_ctrl.md
# cmp_seq_ctrl

Sequential magnitude-comparison controller. It accepts two W-bit operands over a valid/ready handshake and drives a 2-bit compare slice (`cmp_slice2`) MSB-first, one slice per clock. It stops early at the first unequal slice and returns a registered eq/lt/gt result over a second valid/ready handshake. It sits between an operand producer and a result consumer where a full-width parallel comparator is not wanted.

## Interface
- `W`, default 8: operand width. Must be even and ≥ 2. Slice count `S = W/2`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start_valid`  in  1  operand pair on `x`/`y` is valid.
- `start_ready`  out  1  controller can accept operands.
- `x`  in  W  first operand, sampled only on accept.
- `y`  in  W  second operand, sampled only on accept.
- `res_valid`  out  1  result outputs are valid.
- `res_ready`  in  1  consumer takes the result.
- `eq`  out  1  x == y.
- `lt`  out  1  x < y.
- `gt`  out  1  x > y.
- `steps`  out  $clog2(S+1)  number of slices examined for this result.

## Operation
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - `start_ready = 1`.
  - Accept when `start_valid && start_ready`: latch x and y, set slice index `idx = S-1`, go to CMP.
  - On accept, clear eq/lt/gt/steps to 0.
- CMP: each cycle, compare slice `idx`, i.e. bits `[2*idx+1 : 2*idx]` of the latched operands. Increment the step counter.
  - Slice unequal: register lt or gt from the slice, go to DONE.
  - Slice equal and `idx == 0`: register eq = 1, go to DONE.
  - Otherwise: `idx` decrements, stay in CMP.
- DONE:
  - `res_valid = 1`.
  - eq/lt/gt/steps are held stable.
  - On `res_ready`, go to IDLE.
- `start_ready` is 0 in CMP and DONE. `start_valid` in those states is ignored; the operands are not re-sampled.
- While `res_valid = 1`, exactly one of eq/lt/gt is 1.
- Result outputs keep their values after the handshake until the next accept.
- No overlap: the earliest next accept is the cycle after the `res_valid && res_ready` cycle.

## Timing
- Reset: the first rising edge with `rst_n = 0` forces the following, regardless of current state:
  - state = IDLE, so `start_ready = 1`;
  - `res_valid = 0`;
  - eq = lt = gt = 0, steps = 0;
  - `idx` and the latched operands = 0.
- Reset in CMP or DONE aborts the operation. No result is produced.
- Latency: accept at edge t0. `res_valid` rises at edge t0+n, where n = `steps` ∈ [1, S].
  - n = 1 when the top slice differs.
  - n = S when the operands are equal or differ only in slice 0.
- Handshake throughput: with `res_ready` held at 1, one operation takes n+2 cycles (accept, n compare cycles, IDLE cycle).
- All outputs are registered, or decoded directly from the state register. There is no combinational path from `x`/`y`/`start_valid`/`res_ready` to any output.

## Configuration
- `CMP_SIGNED_EN` defined: operands are two's complement. In the top slice (`idx = S-1`), bit W-1 of both operands is inverted before the slice compare. The other slices are unchanged.
- `CMP_SIGNED_EN` undefined: unsigned compare, with all slices treated identically.
- The latency rules are identical in both builds.

## Structure
- Package `cmp_pkg` holds:
  - `cmp_state_t` enum (IDLE, CMP, DONE);
  - `slice_res_t` encoding for the slice outcome (EQ, LT, GT);
  - a localparam helper for the `steps` width.
- Sub-module `cmp_slice2`: combinational 2-bit compare. Inputs are `a[1:0]` and `b[1:0]`; output is `slice_res_t`. It is instantiated once and fed by an `idx`-selected mux.
- `cmp_seq_ctrl` contains the FSM, the operand registers, `idx`, the step counter and the result registers.

## Test plan
All scenarios use W = 8.
- Equal operands: x=0xA5, y=0xA5, `res_ready=1` → `res_valid` at t0+4; eq=1, lt=gt=0, steps=4.
- Early exit: x=0x80, y=0x7F. Unsigned build → gt=1, steps=1, `res_valid` at t0+1. With `CMP_SIGNED_EN` → lt=1, steps=1.
- LSB decides: x=0x12, y=0x13 → lt=1, steps=4.
- Backpressure: x=0x40, y=0x10 → gt=1, steps=1. Hold `res_ready=0` for 5 cycles while toggling `start_valid`, `x` and `y`. Outputs stay gt=1, steps=1; `start_ready=0` throughout; accept occurs only after `res_ready` pulses.
- Reset mid-op: x=0x11, y=0x11; drive `rst_n=0` for 1 cycle at t0+2. Required: `res_valid` never rises, all outputs are 0 and `start_ready=1` after the edge. A new pair x=0x03, y=0x01 then gives gt=1, steps=4.
- Back-to-back: hold `start_valid=1` with `res_ready=1` and three pairs (0x01/0x02, 0xFF/0x00, 0x5A/0x5A) → lt, gt, eq in that order, each separated by the required IDLE cycle.
